// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment scan controller with hex decode, blink, PWM and frame-synchronous updates
module seg_scan_ctrl #(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_FRAMES = 64,
  parameter int DUTY_W       = 3,
  parameter int ACTIVE_LOW   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     blink,
  input  logic [DUTY_W-1:0]     brightness,
  input  logic                  load,
  output logic [DIGITS-1:0]     seg_en,
  output logic [7:0]            seg_out,
  output logic                  upd_done
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int FW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [DIGITS-1:0] EN_INV = {DIGITS{ACTIVE_LOW != 0}};
  localparam logic [7:0] OUT_INV = {8{ACTIVE_LOW != 0}};
  localparam logic [111:0] HEX = {
    7'b1000111, 7'b1001111, 7'b0111101, 7'b1001110,
    7'b0011111, 7'b1110111, 7'b1111011, 7'b1111111,
    7'b1110000, 7'b1011111, 7'b1011011, 7'b0110011,
    7'b1111001, 7'b1101101, 7'b0110000, 7'b1111110
  };
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [FW-1:0]       fcnt;
  logic                bphase;
  logic                pend_v;
  logic [4*DIGITS-1:0] pend_data, act_data;
  logic [DIGITS-1:0]   pend_dp, pend_blank, pend_blink;
  logic [DIGITS-1:0]   act_dp, act_blank, act_blink;
  logic                tick, frame_end, lit;
  logic [3:0]          digit;
  logic [63:0]         thr;
  logic [DIGITS-1:0]   en_nxt;
  logic [7:0]          out_nxt;
  always_comb begin
    tick      = cnt == CW'(SCAN_DIV - 1);
    frame_end = tick && idx == IW'(DIGITS - 1);
    thr       = ((64'(brightness) + 64'd1) * 64'(SCAN_DIV)) >> DUTY_W;
    digit     = act_data[4*idx +: 4];
    lit       = !act_blank[idx] && !(act_blink[idx] && bphase) && 64'(cnt) < thr;
    en_nxt    = lit ? DIGITS'(1) << idx : '0;
    out_nxt   = lit ? {HEX[7*digit +: 7], act_dp[idx]} : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      fcnt       <= '0;
      bphase     <= 1'b0;
      pend_v     <= 1'b0;
      pend_data  <= '0;
      pend_dp    <= '0;
      pend_blank <= '0;
      pend_blink <= '0;
      act_data   <= '0;
      act_dp     <= '0;
      act_blank  <= '1;
      act_blink  <= '0;
      upd_done   <= 1'b0;
      seg_en     <= EN_INV;
      seg_out    <= OUT_INV;
    end else begin
      cnt <= tick ? '0 : cnt + CW'(1);
      if (tick) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      if (frame_end) begin
        fcnt <= fcnt == FW'(BLINK_FRAMES - 1) ? '0 : fcnt + FW'(1);
        if (fcnt == FW'(BLINK_FRAMES - 1)) bphase <= !bphase;
      end
      upd_done <= frame_end && (load || pend_v);
      if (frame_end && load) begin
        {act_data, act_dp, act_blank, act_blink} <= {data, dp, blank, blink};
        pend_v <= 1'b0;
      end else if (frame_end && pend_v) begin
        {act_data, act_dp, act_blank, act_blink} <= {pend_data, pend_dp, pend_blank, pend_blink};
        pend_v <= 1'b0;
      end else if (load) begin
        {pend_data, pend_dp, pend_blank, pend_blink} <= {data, dp, blank, blink};
        pend_v <= 1'b1;
      end
      seg_en  <= en_nxt ^ EN_INV;
      seg_out <= out_nxt ^ OUT_INV;
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: randomized self-checking bench for seg_scan_ctrl against a cycle-index reference model
module tb_seg_scan_ctrl;
  localparam int D = 4, S = 4, BF = 2, W = 2, FL = D * S;
  logic clk = 0, rst_n = 0, load = 0;
  logic [4*D-1:0] data = '0;
  logic [D-1:0] dp = '0, blank = '0, blink = '0;
  logic [W-1:0] brightness = '1;
  logic [D-1:0] seg_en, seg_en_l;
  logic [7:0] seg_out, seg_out_l;
  logic upd_done, upd_done_l;
  int n_chk = 0, n_pass = 0;
  int k;
  logic [4*D-1:0] m_data, p_data;
  logic [D-1:0] m_dp, m_blank, m_blink, p_dp, p_blank, p_blink;
  logic p_v;
  logic [D-1:0] e_en, e_en_l;
  logic [7:0] e_out, e_out_l;
  logic e_upd;
  logic [6:0] hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [7:0] exp_d [4] = '{8'b11111101, 8'b11110010, 8'b11011010, 8'b01100000};
  always #5 clk = ~clk;
  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLINK_FRAMES(BF), .DUTY_W(W), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank), .blink(blink),
    .brightness(brightness), .load(load), .seg_en(seg_en), .seg_out(seg_out), .upd_done(upd_done)
  );
  seg_scan_ctrl #(.DIGITS(D), .SCAN_DIV(S), .BLINK_FRAMES(BF), .DUTY_W(W), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .rst_n(rst_n), .data(data), .dp(dp), .blank(blank), .blink(blink),
    .brightness(brightness), .load(load), .seg_en(seg_en_l), .seg_out(seg_out_l), .upd_done(upd_done_l)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic model_reset();
    k = 0;
    m_data = '0;
    m_dp = '0;
    m_blank = '1;
    m_blink = '0;
    p_v = 0;
  endtask
  task automatic model_step();
    int slot, c, f, thr;
    bit ph, on, bnd;
    slot = (k / S) % D;
    c = k % S;
    f = k / FL;
    ph = ((f / BF) % 2) == 1;
    thr = (int'(brightness) + 1) * S / (1 << W);
    on = !m_blank[slot] && !(m_blink[slot] && ph) && c < thr;
    e_en = '0;
    if (on) e_en[slot] = 1'b1;
    e_out = on ? {hex_tab[m_data[4*slot +: 4]], m_dp[slot]} : 8'h00;
    e_en_l = ~e_en;
    e_out_l = ~e_out;
    bnd = (k % FL) == FL - 1;
    e_upd = bnd && (load || p_v);
    if (bnd && load) begin
      {m_data, m_dp, m_blank, m_blink} = {data, dp, blank, blink};
      p_v = 0;
    end else if (bnd && p_v) begin
      {m_data, m_dp, m_blank, m_blink} = {p_data, p_dp, p_blank, p_blink};
      p_v = 0;
    end else if (load) begin
      {p_data, p_dp, p_blank, p_blink} = {data, dp, blank, blink};
      p_v = 1;
    end
    k++;
  endtask
  task automatic cyc();
    model_step();
    @(negedge clk);
    check("seg_en", seg_en, e_en);
    check("seg_out", seg_out, e_out);
    check("upd_done", upd_done, e_upd);
    check("seg_en_al", seg_en_l, e_en_l);
    check("seg_out_al", seg_out_l, e_out_l);
    check("upd_done_al", upd_done_l, e_upd);
    load = 0;
  endtask
  task automatic wait_upd();
    bit seen = 0;
    for (int i = 0; i < 2 * FL && !seen; i++) begin
      cyc();
      seen = upd_done;
    end
    check("upd_seen", seen, 1);
  endtask
  task automatic check_reset();
    check("rst_en", seg_en, 0);
    check("rst_out", seg_out, 0);
    check("rst_upd", upd_done, 0);
    check("rst_en_al", seg_en_l, 4'hF);
    check("rst_out_al", seg_out_l, 8'hFF);
  endtask
  initial begin
    int cnt_a, cnt_b;
    repeat (2) @(negedge clk);
    check_reset();
    rst_n = 1;
    model_reset();
    repeat (32) cyc();
    data = 16'h1230;
    dp = 4'b0001;
    brightness = 2'd3;
    load = 1;
    wait_upd();
    for (int j = 0; j < FL; j++) begin
      cyc();
      if (j % 4 == 0) check("digit", seg_out, exp_d[j/4]);
      check("walk", seg_en, 4'b1 << (j / 4));
    end
    brightness = 2'd1;
    cnt_a = 0;
    repeat (FL) begin
      cyc();
      if (seg_en != 0) cnt_a++;
    end
    check("pwm_lit", cnt_a, 8);
    brightness = 2'd3;
    blink = 4'b0100;
    load = 1;
    wait_upd();
    cnt_a = 0;
    cnt_b = 0;
    repeat (4 * FL) begin
      cyc();
      if (seg_en[2]) cnt_a++;
      if (seg_en[0]) cnt_b++;
    end
    check("blink_d2", cnt_a, 8);
    check("blink_d0", cnt_b, 16);
    blink = 0;
    while (k % FL != 5) cyc();
    data = 16'h8888;
    load = 1;
    cyc();
    cyc();
    data = 16'hFFFF;
    load = 1;
    wait_upd();
    cnt_a = 0;
    cnt_b = 0;
    repeat (FL) begin
      cyc();
      if (seg_out[7:1] == 7'b1111111) cnt_a++;
      if (seg_out[7:1] == 7'b1000111) cnt_b++;
    end
    check("no_8888", cnt_a, 0);
    check("all_f", cnt_b, 16);
    while (k % FL != FL - 1) cyc();
    data = 16'hABCD;
    load = 1;
    cyc();
    check("coinc_upd", upd_done, 1);
    cyc();
    check("coinc_d0", seg_out, 8'b01111011);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        data = 16'($urandom);
        dp = 4'($urandom);
        blank = 4'($urandom_range(0, 15)) & 4'($urandom);
        blink = 4'($urandom);
        load = 1;
      end
      if ($urandom_range(0, 15) == 0) brightness = 2'($urandom);
      if (i == 250) begin
        load = 0;
        #2 rst_n = 0;
        #1 check_reset();
        @(negedge clk);
        rst_n = 1;
        model_reset();
      end
      cyc();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
